// File: rtl/bus_master_if.sv
// Requester side of the two-master bus: takes one burst command, runs the request/grant
// handshake, drives the beats with valid/ack and releases the bus so priority can rotate.
module bus_master_if #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LEN_W       = 2,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              request,
  input  logic              grant,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StRelease} state_e;

  state_e              state_q;
  logic                we_q;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_q;
  logic [TimerW-1:0]   timer_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                request_q;
  logic                rd_valid_q;
  logic                done_q;
  logic                err_q;

  logic                in_xfer;
  logic                beat_ok;

  assign in_xfer     = (state_q == StXfer);
  // A write beat is only offered once its data is present; losing grant kills valid at once.
  assign bus_valid   = in_xfer & grant & (~we_q | wdata_valid);
  assign beat_ok     = bus_valid & bus_ack;
  assign bus_we      = we_q;
  assign bus_addr    = base_q + ADDR_W'(beat_q);
  assign bus_wdata   = in_xfer ? wdata : '0;
  assign wdata_ready = beat_ok & we_q;
  assign cmd_ready   = (state_q == StIdle);
  assign request     = request_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign done        = done_q;
  assign err         = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      timer_q    <= '0;
      rd_data_q  <= '0;
      request_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            we_q      <= cmd_we;
            base_q    <= cmd_addr;
            len_q     <= cmd_len;
            beat_q    <= '0;
            timer_q   <= '0;
            request_q <= 1'b1;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (grant) state_q <= StXfer;
        end
        StXfer: begin
          if (!grant) begin
            // Beat and timer are kept so the burst resumes where it stopped.
            state_q <= StReq;
          end else if (beat_ok) begin
            timer_q <= '0;
            if (!we_q) begin
              rd_data_q  <= bus_rdata;
              rd_valid_q <= 1'b1;
            end
            if (beat_q == len_q) begin
              done_q    <= 1'b1;
              request_q <= 1'b0;
              state_q   <= StRelease;
            end else begin
              beat_q <= beat_q + LEN_W'(1);
            end
          end else if (bus_valid) begin
            if (timer_q == TimerW'(ACK_TIMEOUT - 1)) begin
              done_q    <= 1'b1;
              err_q     <= 1'b1;
              request_q <= 1'b0;
              state_q   <= StRelease;
            end else begin
              timer_q <= timer_q + TimerW'(1);
            end
          end
        end
        StRelease: begin
          if (!grant) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
